i2s_deserializer: RTL and testbench

I2S_DESERIALIZER -- requirements
Module: i2s_deserializer

---
 rtl/i2s_deserializer_pkg.sv | 16 +
 rtl/i2s_deserializer_edge_sync.sv | 33 +++
 rtl/i2s_deserializer.sv | 237 +++++++++++++++++++++++
 tb/tb_i2s_deserializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_deserializer_pkg.sv
// Shared types and constants for the I2S deserializer.
package i2s_deserializer_pkg;

  // Default number of sample bits captured per channel.
  localparam int I2S_WIDTH_DEFAULT = 24;

  // Width of the saturating bit-slot counter. It covers slots of up to 63 bits.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_deserializer_edge_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
// It also detects a rising edge on bit 0 of the bundle, which carries the bit clock.
module i2s_edge_sync #(
  parameter int N = 1
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_sync,
  output logic         o_rise
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;
  logic         r_prev;

  // Two-stage synchronizer, plus a delayed copy of bit 0 for edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync[0];
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync[0] & ~r_prev;

endmodule

// File: rtl/i2s_deserializer.sv
// I2S receiver: word-select framing, slot-length checking, a stereo pair
// valid/ready holding register, and sticky error flags.
// Optional peak meter: define I2S_DESERIALIZER_PEAK_EN to build it.
//
// state | meaning
// IDLE  | unlocked, or waiting for the first ws change to 0 (left word start)
// LEFT  | collecting a left word
// RIGHT | collecting a right word; the pair closes on the next ws change to 0
module i2s_deserializer
  import i2s_deserializer_pkg::*;
#(
  parameter int WIDTH = I2S_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i2s_bck,
  input  logic             i2s_ws,
  input  logic             i2s_d0,
  input  logic             audio_locked,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clear,
  input  logic             peak_clear,
  output logic [WIDTH-1:0] peak_left,
  output logic [WIDTH-1:0] peak_right
);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [3:0]       w_sync;
  logic             w_bit_edge;
  logic             w_ws;
  logic             w_d0;
  logic             w_locked;
  logic             w_unused_bck;
  logic             w_ws_chg;
  logic [WIDTH-1:0] w_word;
  logic             w_long;
  logic             w_store_left;
  logic             w_pair_done;
  logic             w_short;
  logic             w_load;
  logic             w_drop;
  state_t           w_state_nxt;

  state_t           r_state;
  logic             r_ws_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_left_word;
  logic             r_left_ok;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_left;
  logic [WIDTH-1:0] r_out_right;
  logic             r_overrun;
  logic             r_frame_err;

  // Bit 0 (bck) gets edge detection; ws, d0 and locked only ride the sync path.
  i2s_edge_sync #(.N(4)) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .i_d    ({audio_locked, i2s_d0, i2s_ws, i2s_bck}),
    .o_sync (w_sync),
    .o_rise (w_bit_edge)
  );

  assign w_unused_bck = w_sync[0];
  assign w_ws         = w_sync[1];
  assign w_d0         = w_sync[2];
  assign w_locked     = w_sync[3];

  assign w_ws_chg = w_bit_edge && (w_ws != r_ws_prev);

  // The ws-change edge carries the LSB slot. It only lands in the word when
  // the slot has not already filled all WIDTH bits.
  assign w_word = (r_cnt < FULL_CNT) ? {r_shift[WIDTH-2:0], w_d0} : r_shift;
  assign w_long = (r_cnt >= LAST_SLOT);

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus word-close decisions on each ws change.
  always_comb begin
    w_state_nxt  = r_state;
    w_store_left = 1'b0;
    w_pair_done  = 1'b0;
    w_short      = 1'b0;
    if (!w_locked) begin
      w_state_nxt = IDLE;
    end else if (w_ws_chg) begin
      case (r_state)
        IDLE: begin
          if (!w_ws) w_state_nxt = LEFT;
        end
        LEFT: begin
          if (w_ws) begin
            w_state_nxt = RIGHT;
            if (w_long) w_store_left = 1'b1;
            else        w_short      = 1'b1;
          end
        end
        RIGHT: begin
          if (!w_ws) begin
            w_state_nxt = LEFT;
            if (!w_long)        w_short     = 1'b1;
            else if (r_left_ok) w_pair_done = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_load = w_pair_done && (!r_out_valid || out_ready);
  assign w_drop = w_pair_done && r_out_valid && !out_ready;

  // Keep ws history across lock loss, so the first change after relock is seen correctly.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)           r_ws_prev <= 1'b0;
    else if (w_bit_edge) r_ws_prev <= w_ws;
  end

  // Shift register and saturating slot counter; both are cleared while unlocked.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!w_locked) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_bit_edge) begin
      if (w_ws_chg) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        if (r_cnt < FULL_CNT) r_shift <= {r_shift[WIDTH-2:0], w_d0};
        if (r_cnt != CNT_MAX) r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // Accepted left word, waiting for its right partner within the same frame.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_left_word <= '0;
      r_left_ok   <= 1'b0;
    end else if (!w_locked) begin
      r_left_ok <= 1'b0;
    end else if (w_ws_chg) begin
      r_left_ok <= w_store_left;
      if (w_store_left) r_left_word <= w_word;
    end
  end

  // Output holding register. A new load takes priority over the handshake clear.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_left  <= '0;
      r_out_right <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_left  <= r_left_word;
      r_out_right <= w_word;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clear.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)         r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
      if (w_short)        r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

`ifdef I2S_DESERIALIZER_PEAK_EN
  logic [WIDTH-1:0] r_peak_left;
  logic [WIDTH-1:0] r_peak_right;
  logic [WIDTH-1:0] w_mag_left;
  logic [WIDTH-1:0] w_mag_right;

  // Magnitude of a two's complement sample; the most negative value clips to max positive.
  function automatic logic [WIDTH-1:0] abs_sat(input logic [WIDTH-1:0] v);
    if (!v[WIDTH-1])                         return v;
    else if (v == {1'b1, {(WIDTH-1){1'b0}}}) return {1'b0, {(WIDTH-1){1'b1}}};
    else                                     return -v;
  endfunction

  assign w_mag_left  = abs_sat(r_left_word);
  assign w_mag_right = abs_sat(w_word);

  // Peak hold per channel, updated by each loaded pair; an update wins over peak_clear.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_peak_left  <= '0;
      r_peak_right <= '0;
    end else if (w_load) begin
      if (w_mag_left  > r_peak_left)  r_peak_left  <= w_mag_left;
      if (w_mag_right > r_peak_right) r_peak_right <= w_mag_right;
    end else if (peak_clear) begin
      r_peak_left  <= '0;
      r_peak_right <= '0;
    end
  end

  assign peak_left  = r_peak_left;
  assign peak_right = r_peak_right;
`else
  logic w_unused_peak_clear;
  assign w_unused_peak_clear = peak_clear;
  assign peak_left  = '0;
  assign peak_right = '0;
`endif

endmodule

// File: tb/tb_i2s_deserializer.sv
`timescale 1ns/1ps
// Directed bench for i2s_deserializer with a pair scoreboard and a peak model.
module tb_i2s_deserializer;

  localparam int W        = 24;
  localparam int HALF_BIT = 8;   // clk_in cycles per bck half period
  localparam int LAT      = 3;   // 2 sync flops + the cycle after the detected edge
  localparam int OBS_MAX  = 64;

  logic         clk_in       = 1'b0;
  logic         reset        = 1'b1;
  logic         i2s_bck      = 1'b0;
  logic         i2s_ws       = 1'b0;
  logic         i2s_d0       = 1'b0;
  logic         audio_locked = 1'b0;
  logic         out_ready    = 1'b1;
  logic         err_clear    = 1'b0;
  logic         peak_clear   = 1'b0;
  logic [W-1:0] out_left, out_right, peak_left, peak_right;
  logic         out_valid, overrun, frame_err;

  i2s_deserializer #(.WIDTH(W)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .i2s_bck      (i2s_bck),
    .i2s_ws       (i2s_ws),
    .i2s_d0       (i2s_d0),
    .audio_locked (audio_locked),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .err_clear    (err_clear),
    .peak_clear   (peak_clear),
    .peak_left    (peak_left),
    .peak_right   (peak_right)
  );

  always #10.417 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every completed handshake, together with the cycle it was seen in.
  logic [W-1:0] obs_l   [OBS_MAX];
  logic [W-1:0] obs_r   [OBS_MAX];
  int           obs_cyc [OBS_MAX];
  int           obs_n = 0;
  always @(negedge clk_in) begin
    if (out_valid && out_ready && obs_n < OBS_MAX) begin
      obs_l[obs_n]   <= out_left;
      obs_r[obs_n]   <= out_right;
      obs_cyc[obs_n] <= cyc;
      obs_n          <= obs_n + 1;
    end
  end

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           rise;
    bit           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           exp_total = 0;
  int           rd        = 0;
  int           last_rise = 0;
  int           checks    = 0;
  int           errors    = 0;
  logic [W-1:0] pk_l      = '0;
  logic [W-1:0] pk_r      = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_bit(input logic ws, input logic d);
    i2s_bck = 1'b0; i2s_ws = ws; i2s_d0 = d;
    tick(HALF_BIT);
    i2s_bck = 1'b1; last_rise = cyc;
    tick(HALF_BIT);
  endtask

  // Slot bits first..last-1 of a len-bit slot for channel ch. The final slot
  // bit already carries the other channel's ws. Bits beyond W are zero padding.
  task automatic send_slot(input logic ch, input logic [W-1:0] word, input int len,
                           input int first, input int last);
    for (int i = first; i < last; i++)
      send_bit((i == len - 1) ? ~ch : ch, (i < W) ? word[W-1-i] : 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int len);
    send_slot(1'b0, l, len, 0, len);
    send_slot(1'b1, r, len, 0, len);
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    if (v == most_neg) return {1'b0, {(W-1){1'b1}}};
    if (v[W-1])        return ~v + 1'b1;
    return v;
  endfunction

  task automatic note_load(input logic [W-1:0] l, input logic [W-1:0] r);
`ifdef I2S_DESERIALIZER_PEAK_EN
    if (mag(l) > pk_l) pk_l = mag(l);
    if (mag(r) > pk_r) pk_r = mag(r);
`endif
  endtask

  task automatic expect_pair(input logic [W-1:0] l, input logic [W-1:0] r, input bit lat);
    exp_t e;
    e.l = l; e.r = r; e.rise = last_rise; e.lat = lat;
    exp_q.push_back(e);
    exp_total++;
    note_load(l, r);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    chk({tag, ":pairs"}, obs_n, exp_total);
    while (rd < obs_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ":left"}, obs_l[rd], e.l);
      chk({tag, ":right"}, obs_r[rd], e.r);
      if (e.lat) chk({tag, ":latency"}, obs_cyc[rd] - e.rise, LAT);
      rd++;
    end
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1; tick(1); err_clear = 1'b0; tick(1);
  endtask

  task automatic pulse_peak_clear();
    peak_clear = 1'b1; tick(1); peak_clear = 1'b0; tick(1);
    pk_l = '0; pk_r = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":out_valid"},  out_valid,  0);
    chk({tag, ":out_left"},   out_left,   0);
    chk({tag, ":out_right"},  out_right,  0);
    chk({tag, ":overrun"},    overrun,    0);
    chk({tag, ":frame_err"},  frame_err,  0);
    chk({tag, ":peak_left"},  peak_left,  0);
    chk({tag, ":peak_right"}, peak_right, 0);
  endtask

  initial begin
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0; audio_locked = 1'b1;
    tick(5);

    // Preamble: its closing ws change to 0 moves the FSM from IDLE into LEFT.
    send_slot(1'b1, '0, 4, 0, 4);
    send_frame(24'h123456, 24'hABCDEF, 32); expect_pair(24'h123456, 24'hABCDEF, 1'b1);
    drain("basic");
    chk("basic:frame_err", frame_err, 0);
    chk("basic:overrun", overrun, 0);

    // Slot length boundaries around WIDTH.
    send_frame(24'h7FFFFF, 24'h800001, 24); expect_pair(24'h7FFFFF, 24'h800001, 1'b1);
    drain("slot24");
    send_frame(24'h5A5A5A, 24'h0F0F0F, 25); expect_pair(24'h5A5A5A, 24'h0F0F0F, 1'b1);
    drain("slot25");
    send_frame(24'h111111, 24'h222222, 23);
    drain("slot23");
    chk("slot23:frame_err", frame_err, 1);
    pulse_err_clear();
    chk("slot23:err_clear", frame_err, 0);

    send_frame(24'hCAFE00, 24'hBEEF00, 16);
    drain("short16");
    chk("short16:frame_err", frame_err, 1);
    pulse_err_clear();

    // Backpressure across two frames.
    out_ready = 1'b0;
    send_frame(24'hA1A2A3, 24'hB1B2B3, 32); expect_pair(24'hA1A2A3, 24'hB1B2B3, 1'b0);
    send_frame(24'hC1C2C3, 24'hD1D2D3, 32);
    chk("bp:out_valid", out_valid, 1);
    chk("bp:held_left", out_left, 24'hA1A2A3);
    chk("bp:held_right", out_right, 24'hB1B2B3);
    chk("bp:overrun", overrun, 1);
    pulse_err_clear();
    chk("bp:overrun_clear", overrun, 0);
    chk("bp:still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(3);
    drain("bp");
    chk("bp:valid_drop", out_valid, 0);

    // Lock loss in the middle of a left word.
    send_slot(1'b0, 24'h654321, 32, 0, 10);
    audio_locked = 1'b0; tick(10);
    audio_locked = 1'b1; tick(10);
    send_slot(1'b1, '0, 4, 0, 4);
    send_frame(24'h000001, 24'h7FFFFF, 32); expect_pair(24'h000001, 24'h7FFFFF, 1'b1);
    drain("relock");

    // Peak meter (reads zero when the meter is not built).
    pulse_peak_clear();
    send_frame(24'h800000, 24'h000010, 32); expect_pair(24'h800000, 24'h000010, 1'b1);
    send_frame(24'h100000, 24'hFFFFF0, 32); expect_pair(24'h100000, 24'hFFFFF0, 1'b1);
    drain("peak");
    chk("peak:left", peak_left, pk_l);
    chk("peak:right", peak_right, pk_r);
    pulse_peak_clear();
    chk("peak:clr_left", peak_left, pk_l);
    chk("peak:clr_right", peak_right, pk_r);

    // Reset mid-frame while a pair is held and overrun is set.
    out_ready = 1'b0;
    send_frame(24'h0A0B0C, 24'h0D0E0F, 32); note_load(24'h0A0B0C, 24'h0D0E0F);
    send_frame(24'h102030, 24'h405060, 32);
    chk("rst:pre_overrun", overrun, 1);
    chk("rst:pre_valid", out_valid, 1);
    send_slot(1'b0, 24'h777777, 32, 0, 32);
    send_slot(1'b1, 24'h888888, 32, 0, 6);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_mid");
    pk_l = '0; pk_r = '0;
    tick(3);
    reset = 1'b0; out_ready = 1'b1;
    send_slot(1'b1, 24'h888888, 32, 6, 32);
    send_frame(24'h246813, 24'h135724, 32); expect_pair(24'h246813, 24'h135724, 1'b1);
    drain("after_reset");
    chk("after_reset:frame_err", frame_err, 0);
    chk("after_reset:peak_left", peak_left, pk_l);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
